// File: rtl/aes_stream_host.sv
// Host-side sequencer for the AES buffer engine: loads a payload into port A of the
// shared BRAM, appends the sentinel, runs the engine and streams the result back out.
module aes_stream_host #(
  parameter int MAX_WORDS      = 256,
  parameter int OUT_BASE       = 257,
  parameter int RD_LATENCY     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        decrypt_in,
  input  logic        in_valid_in,
  input  logic [31:0] in_data_in,
  input  logic        in_last_in,
  output logic        in_ready_out,
  output logic        out_valid_out,
  output logic [31:0] out_data_out,
  output logic        out_last_out,
  input  logic        out_ready_in,
  output logic [9:0]  mem_addr_out,
  output logic [3:0]  mem_we_out,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  aes_ctrl_out,
  input  logic        aes_complete_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [1:0]  err_code_out
);
  localparam logic [31:0] SENTINEL_WORD = 32'hDEADBEEF;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SENTINEL, RUN, DRAIN_ADDR, DRAIN_WAIT, DRAIN_HOLD, FINISH
  } state_t;

  state_t        state_reg, state_next;
  logic [8:0]    n_reg, n_next;
  logic [8:0]    i_reg, i_next;
  logic          decrypt_reg, decrypt_next;
  logic [1:0]    err_reg, err_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [LW-1:0] lat_reg, lat_next;
  logic [31:0]   out_data_reg, out_data_next;
  logic          last_idx;
  logic [2:0]    mode_ctrl;
  logic [9:0]    drain_addr;

  assign last_idx   = (i_reg == n_reg - 9'd1);
  assign mode_ctrl  = decrypt_reg ? 3'b010 : 3'b001;
  assign drain_addr = 10'(OUT_BASE) + {1'b0, i_reg};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      i_reg        <= '0;
      decrypt_reg  <= 1'b0;
      err_reg      <= 2'b00;
      tmo_reg      <= '0;
      lat_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      i_reg        <= i_next;
      decrypt_reg  <= decrypt_next;
      err_reg      <= err_next;
      tmo_reg      <= tmo_next;
      lat_reg      <= lat_next;
      out_data_reg <= out_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    i_next        = i_reg;
    decrypt_next  = decrypt_reg;
    err_next      = err_reg;
    tmo_next      = tmo_reg;
    lat_next      = lat_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: if (start_in) begin
        decrypt_next = decrypt_in;
        n_next       = '0;
        err_next     = 2'b00;
        tmo_next     = '0;
        state_next   = LOAD;
      end
      LOAD: if (in_valid_in) begin
        n_next = n_reg + 9'd1;
        // A payload sentinel is stored as-is; the engine will stop short there.
        if (in_data_in == SENTINEL_WORD) err_next = 2'b01;
        if (in_last_in) begin
          state_next = SENTINEL;
        end else if (n_reg + 9'd1 == 9'(MAX_WORDS)) begin
          err_next   = 2'b10;
          state_next = FINISH;
        end
      end
      SENTINEL: state_next = RUN;
      RUN: begin
        if (aes_complete_in) begin
          i_next     = '0;
          state_next = DRAIN_ADDR;
        end else begin
          tmo_next = tmo_reg + TW'(1);
          if (tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            err_next   = 2'b11;
            state_next = FINISH;
          end
        end
      end
      DRAIN_ADDR: begin
        lat_next   = '0;
        state_next = DRAIN_WAIT;
      end
      DRAIN_WAIT: begin
        if (lat_reg == LW'(RD_LATENCY - 1)) begin
          out_data_next = mem_data_in;
          state_next    = DRAIN_HOLD;
        end else begin
          lat_next = lat_reg + LW'(1);
        end
      end
      DRAIN_HOLD: if (out_ready_in) begin
        i_next     = i_reg + 9'd1;
        state_next = last_idx ? FINISH : DRAIN_ADDR;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port-A and handshake outputs decode straight from state so LOAD writes land in the handshake cycle.
  always_comb begin
    in_ready_out  = 1'b0;
    out_valid_out = 1'b0;
    out_last_out  = 1'b0;
    mem_addr_out  = '0;
    mem_we_out    = 4'h0;
    mem_data_out  = '0;
    aes_ctrl_out  = 3'b000;
    done_out      = 1'b0;
    err_code_out  = 2'b00;
    busy_out      = (state_reg != IDLE);
    case (state_reg)
      LOAD: begin
        in_ready_out = 1'b1;
        mem_addr_out = {1'b0, n_reg};
        mem_data_out = in_data_in;
        mem_we_out   = in_valid_in ? 4'hf : 4'h0;
      end
      SENTINEL: begin
        mem_addr_out = {1'b0, n_reg};
        mem_data_out = SENTINEL_WORD;
        mem_we_out   = 4'hf;
      end
      RUN: aes_ctrl_out = mode_ctrl;
      DRAIN_ADDR, DRAIN_WAIT: begin
        aes_ctrl_out = mode_ctrl;
        mem_addr_out = drain_addr;
      end
      DRAIN_HOLD: begin
        aes_ctrl_out  = mode_ctrl;
        mem_addr_out  = drain_addr;
        out_valid_out = 1'b1;
        out_last_out  = last_idx;
      end
      FINISH: begin
        done_out     = 1'b1;
        err_code_out = err_reg;
      end
      default: ;
    endcase
  end

  assign out_data_out = out_data_reg;
endmodule

// File: tb/tb_aes_stream_host.sv
// Randomised scoreboard bench for aes_stream_host with a BRAM + engine model on the memory side.
module tb_aes_stream_host;
  localparam int OUT_BASE = 257;
  localparam int TMO      = 20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0, decrypt_in = 1'b0;
  logic        in_valid_in = 1'b0, in_last_in = 1'b0;
  logic [31:0] in_data_in = '0;
  logic        in_ready_out, out_valid_out, out_last_out;
  logic [31:0] out_data_out;
  logic        out_ready_in = 1'b1;
  logic [9:0]  mem_addr_out;
  logic [3:0]  mem_we_out;
  logic [31:0] mem_data_out, mem_data_in;
  logic [2:0]  aes_ctrl_out;
  logic        aes_complete_in;
  logic        busy_out, done_out;
  logic [1:0]  err_code_out;

  always #5 clk_in = ~clk_in;

  aes_stream_host #(.MAX_WORDS(256), .OUT_BASE(OUT_BASE), .RD_LATENCY(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .decrypt_in(decrypt_in),
    .in_valid_in(in_valid_in), .in_data_in(in_data_in), .in_last_in(in_last_in),
    .in_ready_out(in_ready_out), .out_valid_out(out_valid_out), .out_data_out(out_data_out),
    .out_last_out(out_last_out), .out_ready_in(out_ready_in), .mem_addr_out(mem_addr_out),
    .mem_we_out(mem_we_out), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .aes_ctrl_out(aes_ctrl_out), .aes_complete_in(aes_complete_in), .busy_out(busy_out),
    .done_out(done_out), .err_code_out(err_code_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Toy cipher standing in for AES; only the mode-dependence and truncation matter here.
  function automatic logic [31:0] cipher(input logic dec, input logic [31:0] w);
    return dec ? ({w[7:0], w[31:8]} ^ 32'h3C6EF372) : ({w[23:0], w[31:24]} ^ 32'hA54FF53A);
  endfunction

  // Shared BRAM (2-cycle port-A read) and a behavioural engine on the other port.
  logic [31:0] mem [0:1023];
  logic [31:0] rd_p1, rd_p2;
  logic        aes_complete = 1'b0;
  int          eng_cnt = 0;
  bit          hang_engine = 1'b0;
  assign mem_data_in     = rd_p2;
  assign aes_complete_in = aes_complete;

  function automatic int first_sentinel();
    for (int k = 0; k <= 256; k++) if (mem[k] === 32'hDEADBEEF) return k;
    return 256;
  endfunction

  always @(posedge clk_in) begin
    if (mem_we_out == 4'hf) mem[mem_addr_out] <= mem_data_out;
    rd_p1 <= mem[mem_addr_out];
    rd_p2 <= rd_p1;
    if (aes_ctrl_out == 3'b000) begin
      eng_cnt      <= 0;
      aes_complete <= 1'b0;
    end else if (!aes_complete && !hang_engine) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 6) begin
        for (int k = 0; k < 256; k++)
          mem[OUT_BASE + k] <= (k < first_sentinel()) ? cipher(aes_ctrl_out == 3'b010, mem[k]) : 32'h0;
        aes_complete <= 1'b1;
      end
    end
  end

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [1:0]  done_q[$];
  exp_t        mon_e;
  logic [2:0]  exp_ctrl = 3'b001;
  int          wr_count = 0, ctrl_cycles = 0, out_count = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int          ready_mode = 0;
  int          cyc = 0;

  initial forever begin
    @(posedge clk_in); #1;
    cyc++;
    case (ready_mode)
      0:       out_ready_in = 1'b1;
      1:       out_ready_in = cyc[0];
      default: out_ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake and done pulse.
  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      if (start_in && !busy_out) begin
        wr_count = 0; ctrl_cycles = 0; out_count = 0;
      end
      if (mem_we_out != 4'h0) begin
        wr_count++;
        last_wr_addr = mem_addr_out;
        last_wr_data = mem_data_out;
        check("write enable value", 32'(mem_we_out), 32'hf);
        check("no write while engine active", 32'(aes_ctrl_out), 32'h0);
      end
      if (aes_ctrl_out != 3'b000) begin
        ctrl_cycles++;
        check("ctrl mode", 32'(aes_ctrl_out), 32'(exp_ctrl));
      end
      if (prev_stall) begin
        check("stall valid held", 32'(out_valid_out), 32'h1);
        check("stall data held", out_data_out, prev_data);
      end
      if (out_valid_out && out_ready_in) begin
        out_count++;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected output: got %h expected none", out_data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("out data", out_data_out, mon_e.data);
          check("out last", 32'(out_last_out), 32'(mon_e.last));
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected done: got err %0d expected no done", err_code_out);
        end else begin
          check("done err code", 32'(err_code_out), 32'(done_q.pop_front()));
        end
      end
      prev_stall = out_valid_out && !out_ready_in;
      prev_data  = out_data_out;
    end
  end

  task automatic start_job(input logic dec);
    @(posedge clk_in); #1;
    start_in = 1'b1; decrypt_in = dec; exp_ctrl = dec ? 3'b010 : 3'b001;
    @(posedge clk_in); #1;
    start_in = 1'b0; decrypt_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit bubbles);
    bit ok = 1'b0;
    if (bubbles && $urandom_range(0, 3) == 0) begin
      in_valid_in = 1'b0;
      @(posedge clk_in); #1;
    end
    in_valid_in = 1'b1; in_data_in = d; in_last_in = last;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      if (in_ready_out) begin ok = 1'b1; break; end
    end
    check("input accepted", 32'(ok), 32'h1);
    @(posedge clk_in); #1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_in);
      if (!busy_out) begin ok = 1'b1; break; end
    end
    check("job ends within budget", 32'(ok), 32'h1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    return (w == 32'hDEADBEEF) ? 32'h0 : w;
  endfunction

  // Full job with in_last on the final word; hang selects the timeout scenario.
  task automatic run_job(input logic dec, input logic [31:0] words[$], input bit bubbles, input bit hang);
    int n = words.size();
    int t = n;
    exp_t e;
    for (int k = n - 1; k >= 0; k--) if (words[k] == 32'hDEADBEEF) t = k;
    hang_engine = hang;
    if (hang) begin
      done_q.push_back(2'b11);
    end else begin
      for (int k = 0; k < n; k++) begin
        e.data = (k < t) ? cipher(dec, words[k]) : 32'h0;
        e.last = (k == n - 1);
        exp_q.push_back(e);
      end
      done_q.push_back((t < n) ? 2'b01 : 2'b00);
    end
    start_job(dec);
    for (int k = 0; k < n; k++) send_word(words[k], k == n - 1, bubbles);
    in_valid_in = 1'b0; in_last_in = 1'b0;
    wait_idle(200 + 16 * n);
    check("write count", 32'(wr_count), 32'(n + 1));
    check("sentinel address", 32'(last_wr_addr), 32'(n));
    check("sentinel data", last_wr_data, 32'hDEADBEEF);
    for (int k = 0; k < n; k++) check("bram payload", mem[k], words[k]);
    check("output word count", 32'(out_count), hang ? 32'h0 : 32'(n));
    if (hang) check("run cycles before timeout", 32'(ctrl_cycles), 32'(TMO));
    check("scoreboard drained", 32'(exp_q.size() + done_q.size()), 32'h0);
    hang_engine = 1'b0;
  endtask

  logic [31:0] words[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("reset busy", 32'(busy_out), 32'h0);
    check("reset ready", 32'(in_ready_out), 32'h0);
    check("reset valid", 32'(out_valid_out), 32'h0);
    check("reset done", 32'(done_out), 32'h0);
    check("reset ctrl", 32'(aes_ctrl_out), 32'h0);
    check("reset we", 32'(mem_we_out), 32'h0);
    check("reset addr", 32'(mem_addr_out), 32'h0);
    check("reset wdata", mem_data_out, 32'h0);
    check("reset out data", out_data_out, 32'h0);
    check("reset err", 32'(err_code_out), 32'h0);
    rst_in = 1'b0;

    // Encrypt, 4 fixed words.
    words = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    run_job(1'b0, words, 1'b0, 1'b0);

    // Decrypt, 6 words, downstream stalling every other cycle.
    ready_mode = 1;
    words = {};
    for (int k = 0; k < 6; k++) words.push_back(rand_word());
    run_job(1'b1, words, 1'b0, 1'b0);

    // Sentinel collision at payload word 3.
    ready_mode = 0;
    words = {};
    for (int k = 0; k < 5; k++) words.push_back(rand_word());
    words[2] = 32'hDEADBEEF;
    run_job(1'b0, words, 1'b0, 1'b0);

    // Overflow: 256 words without last, then further words offered.
    done_q.push_back(2'b10);
    start_job(1'b0);
    for (int k = 0; k < 256; k++) send_word(rand_word(), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      in_data_in = rand_word();
      @(negedge clk_in);
      check("ready low after overflow", 32'(in_ready_out), 32'h0);
      @(posedge clk_in); #1;
    end
    in_valid_in = 1'b0;
    wait_idle(50);
    check("overflow write count", 32'(wr_count), 32'd256);
    check("overflow last write addr", 32'(last_wr_addr), 32'd255);
    check("overflow engine never started", 32'(ctrl_cycles), 32'h0);
    check("overflow scoreboard drained", 32'(done_q.size()), 32'h0);

    // Timeout with a silent engine.
    words = '{32'h12345678};
    run_job(1'b1, words, 1'b0, 1'b1);

    // Full-size job: sentinel lands at address 256.
    words = {};
    for (int k = 0; k < 256; k++) words.push_back(rand_word());
    run_job(1'b0, words, 1'b0, 1'b0);

    // Randomised jobs with bubbles and random backpressure.
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      words = {};
      for (int k = 0; k < $urandom_range(1, 24); k++) words.push_back(rand_word());
      if ($urandom_range(0, 3) == 0) words[$urandom_range(0, words.size() - 1)] = 32'hDEADBEEF;
      run_job(1'($urandom_range(0, 1)), words, 1'b1, 1'b0);
    end

    // Asynchronous reset during DRAIN_WAIT, then a fresh 1-word job.
    ready_mode = 0;
    start_job(1'b1);
    for (int k = 0; k < 3; k++) send_word(rand_word(), k == 2, 1'b0);
    in_valid_in = 1'b0; in_last_in = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk_in);
        if (mem_addr_out == 10'(OUT_BASE) && aes_ctrl_out != 3'b000) begin seen = 1'b1; break; end
      end
      check("reached drain", 32'(seen), 32'h1);
    end
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    #1;
    check("midjob reset busy", 32'(busy_out), 32'h0);
    check("midjob reset ctrl", 32'(aes_ctrl_out), 32'h0);
    check("midjob reset addr", 32'(mem_addr_out), 32'h0);
    check("midjob reset we", 32'(mem_we_out), 32'h0);
    check("midjob reset valid", 32'(out_valid_out), 32'h0);
    check("midjob reset done", 32'(done_out), 32'h0);
    #1;
    rst_in = 1'b0;
    words = '{32'hCAFEF00D};
    run_job(1'b0, words, 1'b0, 1'b0);

    repeat (5) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
